// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO registers.
// Fixed-latency model: operands are latched on acceptance, the result is
// computed from the latched copies and committed when the cycle counter
// reaches the op-class latency. MTHI/MTLO write immediately.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (op codes 7-10); without it those codes behave as NONE.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_mul_op;
  logic        is_div_op;
  logic [63:0] smul, umul, mul_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Decode the incoming op into the classes that start a multi-cycle run.
  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    if ((op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU))
      is_mul_op = 1'b1;
`endif
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Multiply-class result from the latched operands; accumulating forms
  // use the current HI/LO, which cannot change while the unit is busy.
  always_comb begin
    smul    = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    umul    = {32'd0, a_q} * {32'd0, b_q};
    mul_res = (op_q == OP_MULTU) ? umul : smul;
`ifdef MDU_MADD_EN
    case (op_q)
      OP_MADD:  mul_res = {hi_q, lo_q} + smul;
      OP_MADDU: mul_res = {hi_q, lo_q} + umul;
      OP_MSUB:  mul_res = {hi_q, lo_q} - smul;
      OP_MSUBU: mul_res = {hi_q, lo_q} - umul;
      default:  ;
    endcase
`endif
  end

  // Divide on magnitudes so the most-negative / -1 case wraps cleanly;
  // quotient truncates toward zero, remainder takes the dividend's sign.
  always_comb begin
    a_neg = (op_q == OP_DIV) && a_q[31];
    b_neg = (op_q == OP_DIV) && b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state: accept only when idle, count latency, commit at the end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul_op || is_div_op) begin
            state_d = is_mul_op ? MUL : DIV;
            cnt_d   = 4'd1;
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      MUL: begin
        if (cnt_q == MUL_N) begin
          state_d      = IDLE;
          cnt_d        = 4'd0;
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DIV: begin
        if (cnt_q == DIV_N) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
          // Divide by zero still completes but leaves HI/LO alone.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State register; reset wins over any simultaneous request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Outputs: stall is combinational so D-stage sees a same-cycle request.
  always_comb begin
    busy  = (state_q != IDLE);
    stall = md_use & (busy | (start & (is_mul_op | is_div_op)));
    done  = done_q;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: driver predicts per-cycle outputs from an arithmetic model
// and queues them; a negedge monitor pops and compares against the DUT.
module tb_mdu_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, md_use;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use(md_use), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo;
  int          m_rem;
  logic [63:0] m_pend;
  bit          m_commit, m_done;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare every observable output once per cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("busy",  {31'd0, busy},  {31'd0, e.busy});
      chk("done",  {31'd0, done},  {31'd0, e.done});
      chk("stall", {31'd0, stall}, {31'd0, e.stall});
      chk("hi",    hi, e.hi);
      chk("lo",    lo, e.lo);
    end
  end

  task automatic launch(input int n, input logic [63:0] res, input bit commit);
    m_rem    = n;
    m_pend   = res;
    m_commit = commit;
  endtask

  // Model of one rising edge, written from the op semantics.
  task automatic model_step(input bit r, input bit s, input logic [3:0] o,
                            input logic [31:0] aa, input logic [31:0] bb);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(aa));
    sb  = longint'($signed(bb));
    ua  = {32'd0, aa};
    ub  = {32'd0, bb};
    acc = {m_hi, m_lo};
    if (r) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_commit) {m_hi, m_lo} = m_pend;
        m_done = 1;
      end
    end else if (s) begin
      case (o)
        4'd1: launch(MUL_N, 64'(sa * sb), 1);
        4'd2: launch(MUL_N, ua * ub, 1);
        4'd3: begin
          if (bb == 0) launch(DIV_N, 64'd0, 0);
          else begin
            sq = sa / sb; sr = sa % sb;
            launch(DIV_N, {sr[31:0], sq[31:0]}, 1);
          end
        end
        4'd4: begin
          if (bb == 0) launch(DIV_N, 64'd0, 0);
          else launch(DIV_N, {32'(ua % ub), 32'(ua / ub)}, 1);
        end
        4'd5: m_hi = aa;
        4'd6: m_lo = aa;
        4'd7:  if (MADD_EN) launch(MUL_N, acc + 64'(sa * sb), 1);
        4'd8:  if (MADD_EN) launch(MUL_N, acc + ua * ub, 1);
        4'd9:  if (MADD_EN) launch(MUL_N, acc - 64'(sa * sb), 1);
        4'd10: if (MADD_EN) launch(MUL_N, acc - ua * ub, 1);
        default: ;
      endcase
    end
  endtask

  // One clock cycle of stimulus: predict this cycle's outputs, then edge.
  task automatic cyc(input bit r, input bit s, input logic [3:0] o,
                     input logic [31:0] aa, input logic [31:0] bb, input bit mu);
    exp_t e;
    bit   cls;
    reset = r; start = s; op = o; a = aa; b = bb; md_use = mu;
    cls     = (o >= 4'd1 && o <= 4'd4) || (MADD_EN && o >= 4'd7 && o <= 4'd10);
    e.busy  = (m_rem > 0);
    e.done  = m_done;
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.stall = mu && ((m_rem > 0) || (s && cls));
    expq.push_back(e);
    @(posedge clk);
    model_step(r, s, o, aa, bb);
    #1;
  endtask

  task automatic idle(input int n, input bit mu);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, $urandom, $urandom, mu);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          sel;
    reset = 1; start = 0; op = 0; a = 0; b = 0; md_use = 0;
    m_hi = 0; m_lo = 0; m_rem = 0; m_pend = 0; m_commit = 0; m_done = 0;
    @(posedge clk); #1;
    cyc(1, 1, 4'd1, 32'd5, 32'd6, 0);

    // MULT -2 * 3, operands scrambled afterwards
    cyc(0, 1, 4'd1, 32'hFFFFFFFE, 32'd3, 1);
    idle(6, 1);
    // DIV -7 / 2, then DIVU by zero
    cyc(0, 1, 4'd3, 32'hFFFFFFF9, 32'd2, 0);
    idle(11, 0);
    cyc(0, 1, 4'd4, 32'd7, 32'd0, 0);
    idle(11, 0);
    // MTHI, then MULT followed by a DIVU that must be ignored
    cyc(0, 1, 4'd5, 32'h12345678, 32'd0, 0);
    cyc(0, 1, 4'd1, 32'd3, 32'd4, 0);
    cyc(0, 1, 4'd4, 32'd100, 32'd7, 1);
    idle(2, 1);
    idle(5, 0);
    // Most-negative / -1
    cyc(0, 1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    idle(11, 0);
    // Reset at the third edge after a DIV is accepted
    cyc(0, 1, 4'd3, 32'd100, 32'd7, 0);
    idle(2, 0);
    cyc(1, 0, 4'd0, 32'd0, 32'd0, 0);
    idle(3, 0);
    // Accumulate op: HI=0, LO=all ones, MADDU 1*1
    cyc(0, 1, 4'd5, 32'd0, 32'd0, 0);
    cyc(0, 1, 4'd6, 32'hFFFFFFFF, 32'd0, 0);
    cyc(0, 1, 4'd8, 32'd1, 32'd1, 1);
    idle(6, 0);
    // MSUB from a known accumulator
    cyc(0, 1, 4'd9, 32'hFFFFFFFF, 32'd2, 1);
    idle(6, 0);

    // Randomized traffic with changing operands and occasional reset
    for (int i = 0; i < 600; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (sel == 2) rb = {28'd0, 4'($urandom_range(1, 15))};
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
          4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 1) == 1);
    end
    idle(16, 1);

    @(negedge clk);
    @(negedge clk);
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
